// File: rtl/mul_seq.sv
// mul_seq: shift-add MUL/MLA sequencer that borrows the shared ALU while busy.
// Rev 1.0
`default_nettype none

module mul_seq #(
  parameter int         WIDTH      = 32,
  parameter logic [1:0] ADD_CODE   = 2'b00,
  parameter bit         EARLY_TERM = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             acc_en,
  input  logic [WIDTH-1:0] op_rn,
  input  logic [WIDTH-1:0] op_rm,
  input  logic [WIDTH-1:0] op_ra,
  input  logic [WIDTH-1:0] dp_a,
  input  logic [WIDTH-1:0] dp_b,
  input  logic [1:0]       dp_ctrl,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_out,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;
  logic               last_iter;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    result_d  = result_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    // Early exit looks at the multiplier as it will be after this iteration's shift.
    last_iter = (cnt_q == CNT_W'(WIDTH - 1)) ||
                (EARLY_TERM && ((mplier_q >> 1) == '0));

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d  = op_rn;
          mplier_d = op_rm;
          acc_d    = acc_en ? op_ra : '0;
          cnt_d    = '0;
          state_d  = S_ITER;
        end
      end
      S_ITER: begin
        if (mplier_q[0]) begin
          acc_d = alu_out;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (last_iter) begin
          state_d  = S_DONE;
          done_d   = 1'b1;
          result_d = acc_d;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign stall  = busy;
  assign done   = done_q;
  assign result = result_q;

  // ALU ownership: datapath when idle, sequencer (acc + mcand) otherwise.
  always_comb begin
    if (busy) begin
      alu_a    = acc_q;
      alu_b    = mcand_q;
      alu_ctrl = ADD_CODE;
    end else begin
      alu_a    = dp_a;
      alu_b    = dp_b;
      alu_ctrl = dp_ctrl;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mul_seq.sv
// tb_mul_seq: randomized self-checking bench for mul_seq against an arithmetic reference model.
// Rev 1.0
`default_nettype none

module tb_mul_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start0, start1, acc_en;
  logic [31:0] op_rn, op_rm, op_ra, dp_a, dp_b;
  logic [1:0]  dp_ctrl;
  logic [31:0] alu_a0, alu_b0, alu_out0, result0;
  logic [31:0] alu_a1, alu_b1, alu_out1, result1;
  logic [1:0]  alu_ctrl0, alu_ctrl1;
  logic        busy0, stall0, done0, busy1, stall1, done1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] c);
    case (c)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a & b;
      default: return a | b;
    endcase
  endfunction

  assign alu_out0 = alu_model(alu_a0, alu_b0, alu_ctrl0);
  assign alu_out1 = alu_model(alu_a1, alu_b1, alu_ctrl1);

  mul_seq #(.WIDTH(32), .ADD_CODE(2'b00), .EARLY_TERM(1'b1)) dut_et (
    .clk(clk), .rst_n(rst_n), .start(start0), .acc_en(acc_en),
    .op_rn(op_rn), .op_rm(op_rm), .op_ra(op_ra),
    .dp_a(dp_a), .dp_b(dp_b), .dp_ctrl(dp_ctrl),
    .alu_a(alu_a0), .alu_b(alu_b0), .alu_ctrl(alu_ctrl0), .alu_out(alu_out0),
    .busy(busy0), .stall(stall0), .done(done0), .result(result0)
  );

  mul_seq #(.WIDTH(32), .ADD_CODE(2'b00), .EARLY_TERM(1'b0)) dut_full (
    .clk(clk), .rst_n(rst_n), .start(start1), .acc_en(acc_en),
    .op_rn(op_rn), .op_rm(op_rm), .op_ra(op_ra),
    .dp_a(dp_a), .dp_b(dp_b), .dp_ctrl(dp_ctrl),
    .alu_a(alu_a1), .alu_b(alu_b1), .alu_ctrl(alu_ctrl1), .alu_out(alu_out1),
    .busy(busy1), .stall(stall1), .done(done1), .result(result1)
  );

  // Number of ITER cycles from the multiplier's highest set bit.
  function automatic int ref_iters(input logic [31:0] rm, input bit early);
    int n;
    if (!early) return 32;
    n = 1;
    for (int i = 0; i < 32; i++) begin
      if (rm[i]) n = i + 1;
    end
    return n;
  endfunction

  task automatic run_op(input bit which, input logic [31:0] rn, input logic [31:0] rm,
                        input logic [31:0] ra, input bit en, input string name);
    logic [31:0] exp_res, r;
    int          it;
    logic        b, s, d, eb;
    exp_res = rn * rm + (en ? ra : 32'd0);
    it = ref_iters(rm, !which);
    @(negedge clk);
    op_rn = rn; op_rm = rm; op_ra = ra; acc_en = en;
    if (which) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0; start1 = 1'b0;
    op_rn = $urandom; op_rm = $urandom; op_ra = $urandom; acc_en = 1'($urandom_range(0, 1));
    for (int k = 1; k <= it + 2; k++) begin
      @(negedge clk);
      b = which ? busy1 : busy0;
      s = which ? stall1 : stall0;
      d = which ? done1 : done0;
      r = which ? result1 : result0;
      eb = (k <= it + 1);
      checks++;
      if (b !== eb || s !== eb) begin
        errors++;
        $display("FAIL %s busy cyc %0d: busy=%b stall=%b want %b", name, k, b, s, eb);
      end
      checks++;
      if (d !== (k == it + 1)) begin
        errors++;
        $display("FAIL %s done cyc %0d: got %b want %b", name, k, d, (k == it + 1));
      end
      if (k >= it + 1) begin
        checks++;
        if (r !== exp_res) begin
          errors++;
          $display("FAIL %s result cyc %0d: got %h want %h", name, k, r, exp_res);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; acc_en = 1'b0;
    op_rn = '0; op_rm = '0; op_ra = '0;
    dp_a = 32'hA5A5_0001; dp_b = 32'h5A5A_0002; dp_ctrl = 2'b11;
    #12;
    checks++;
    if (busy0 !== 1'b0 || stall0 !== 1'b0 || done0 !== 1'b0 || result0 !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: busy=%b stall=%b done=%b result=%h want 0 0 0 0",
               busy0, stall0, done0, result0);
    end
    checks++;
    if (alu_a0 !== dp_a || alu_b0 !== dp_b || alu_ctrl0 !== dp_ctrl) begin
      errors++;
      $display("FAIL reset_passthru: alu=%h %h %b want %h %h %b",
               alu_a0, alu_b0, alu_ctrl0, dp_a, dp_b, dp_ctrl);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    run_op(0, 32'd7, 32'd6, 32'd0, 1'b0, "mul_basic");
    run_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, "mul_wrap");
    run_op(0, 32'd3, 32'd4, 32'd10, 1'b1, "mla_basic");
    run_op(0, 32'd1234, 32'd0, 32'd5, 1'b1, "mla_zero_rm");
    run_op(1, 32'hDEAD_BEEF, 32'd1, 32'd0, 1'b0, "full_rm1");
    run_op(1, 32'd7, 32'd6, 32'd9, 1'b1, "full_small");
  endtask

  task automatic test_random();
    logic [31:0] rn, rm, ra;
    for (int i = 0; i < 16; i++) begin
      rn = $urandom;
      rm = $urandom >> $urandom_range(0, 31);
      ra = $urandom;
      run_op(i % 5 == 4, rn, rm, ra, 1'($urandom_range(0, 1)), "random");
    end
  endtask

  task automatic test_arbitration();
    logic [31:0] rn, ra, exp_b;
    rn = 32'h0000_1234; ra = 32'h0000_0077;
    @(negedge clk);
    dp_a = 32'h10; dp_b = 32'h20; dp_ctrl = 2'b01;
    #1;
    checks++;
    if (alu_a0 !== 32'h10 || alu_b0 !== 32'h20 || alu_ctrl0 !== 2'b01) begin
      errors++;
      $display("FAIL idle_passthru: alu=%h %h %b want 10 20 01", alu_a0, alu_b0, alu_ctrl0);
    end
    op_rn = rn; op_rm = 32'h0000_00FF; op_ra = ra; acc_en = 1'b1; start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      dp_a = $urandom; dp_b = $urandom; dp_ctrl = 2'b01;
      #1;
      if (k <= 9) begin
        exp_b = rn << (k - 1);
        checks++;
        if (alu_ctrl0 !== 2'b00 || alu_b0 !== exp_b) begin
          errors++;
          $display("FAIL busy_owner cyc %0d: ctrl=%b b=%h want 00 %h", k, alu_ctrl0, alu_b0, exp_b);
        end
        if (k == 1) begin
          checks++;
          if (alu_a0 !== ra) begin
            errors++;
            $display("FAIL busy_acc_init: alu_a=%h want %h", alu_a0, ra);
          end
        end
      end else begin
        checks++;
        if (alu_a0 !== dp_a || alu_b0 !== dp_b || alu_ctrl0 !== dp_ctrl) begin
          errors++;
          $display("FAIL passthru_restore: alu=%h %h %b want %h %h %b",
                   alu_a0, alu_b0, alu_ctrl0, dp_a, dp_b, dp_ctrl);
        end
      end
    end
    checks++;
    if (result0 !== rn * 32'hFF + ra) begin
      errors++;
      $display("FAIL arb_result: got %h want %h", result0, rn * 32'hFF + ra);
    end
  endtask

  task automatic test_back_to_back();
    int it, ndone;
    it = ref_iters(32'h1F, 1'b1);
    ndone = 0;
    @(negedge clk);
    op_rn = 32'd9; op_rm = 32'h1F; op_ra = 32'd0; acc_en = 1'b0; start0 = 1'b1;
    for (int k = 1; k <= it + 6; k++) begin
      @(negedge clk);
      start0 = 1'b0;
      if (done0 === 1'b1) ndone++;
      if (k == 2 || k == it + 1) begin
        op_rn = 32'd100; op_rm = 32'd3; op_ra = 32'd1; acc_en = 1'b1; start0 = 1'b1;
      end
    end
    checks++;
    if (ndone != 1) begin
      errors++;
      $display("FAIL b2b_done_count: got %0d want 1", ndone);
    end
    checks++;
    if (result0 !== 32'd279 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_result: result=%h busy=%b want %h 0", result0, busy0, 32'd279);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    op_rn = 32'hFFFF_FFFF; op_rm = 32'hFFFF_FFFF; acc_en = 1'b0; start0 = 1'b1;
    dp_a = 32'h0BAD_F00D; dp_b = 32'h1234_5678; dp_ctrl = 2'b10;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy0 !== 1'b0 || done0 !== 1'b0 || result0 !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_state: busy=%b done=%b result=%h want 0 0 0", busy0, done0, result0);
    end
    checks++;
    if (alu_a0 !== dp_a || alu_b0 !== dp_b || alu_ctrl0 !== dp_ctrl) begin
      errors++;
      $display("FAIL reset_mid_passthru: alu=%h %h %b want %h %h %b",
               alu_a0, alu_b0, alu_ctrl0, dp_a, dp_b, dp_ctrl);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(0, 32'd5, 32'd5, 32'd0, 1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_arbitration();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
